mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be as listed in REQ-002 to REQ-011.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 ALUOp  input  5  operation code (ALU encoding): MUL 10101, MULH 10110, MULU 10111, DIV 11010, DIVU 11011, REM 11100, REMU 11101.
REQ-006 A  input  32  multiplicand / dividend.
REQ-007 B  input  32  multiplier / divisor.
REQ-008 Busy  output  1  operation in progress.
REQ-009 Done  output  1  one-cycle pulse; Result/Error valid.
REQ-010 Result  output  32  operation result; holds until the next Done.
REQ-011 Error  output  1  unsupported ALUOp; valid with Done.

Function
REQ-012 States SHALL be IDLE, PREP, CALC, FIX and DONE.
REQ-013 IDLE: Start=1 SHALL latch A, B and ALUOp, set Busy=1 and go to PREP; otherwise stay in IDLE.
REQ-014 PREP: compute magnitudes for signed ops (MUL, MULH, DIV, REM) and the result sign; clear iteration counter; go to CALC.
REQ-015 CALC: exactly 32 iterations, one per clock; shift-add for multiply, restoring shift-subtract for divide; then go to FIX.
REQ-016 FIX: apply sign correction, register Result, pulse Done=1, clear Busy, go to DONE.
REQ-017 DONE: go to IDLE after one cycle; Start is ignored in this cycle.
REQ-018 Latency: Done SHALL assert exactly 34 clocks after the accepting edge, independent of operand values.
REQ-019 Busy SHALL be high in the 34 cycles between the accept edge and Done, and low in the Done cycle.
REQ-020 Start, A, B and ALUOp SHALL be ignored while Busy=1 or in DONE; latched operands are not disturbed.
REQ-021 MUL SHALL return product[31:0]; MULH the signed-by-signed product[63:32]; MULU the unsigned product[63:32].
REQ-022 DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-023 DIVU/REMU SHALL return the unsigned quotient and remainder.
REQ-024 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return A; Error=0; latency unchanged.
REQ-025 Signed overflow (DIV 0x80000000 by 0xFFFFFFFF): quotient SHALL be 0x80000000 and REM SHALL be 0; latency unchanged.
REQ-026 Unsupported ALUOp: Start SHALL still be accepted, skip CALC, and go PREP to FIX.
REQ-027 Unsupported ALUOp: Done SHALL assert 2 clocks after accept with Result=0 and Error=1.
REQ-028 Error SHALL be 0 on every Done for a supported op and SHALL hold its value with Result.

Reset
REQ-029 Reset=1 SHALL immediately force IDLE, Busy=0, Done=0, Result=0, Error=0 and counter=0, asynchronously to Clk.
REQ-030 Reset mid-operation SHALL abort with no Done pulse; the first Start after reset deassertion starts a fresh operation.

Verification
REQ-031 MUL A=10, B=5 -> Done exactly 34 clocks after accept; Result=50; Error=0.
REQ-032 DIV A=-7, B=2 -> Result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-033 MULH A=B=0xFFFFFFFF -> 0x00000000; MULU with the same operands -> 0xFFFFFFFE.
REQ-034 DIVU A=10, B=0 -> 0xFFFFFFFF; REMU A=10, B=0 -> 10; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with those operands -> 0.
REQ-035 Start MUL A=3, B=4; at cycle 10 pulse Start DIV A=100, B=7 -> only one Done, Result=12; then Reset at cycle 20 of a new op -> Busy=0 immediately and no Done.
REQ-036 ALUOp=00000 with Start -> Done 2 clocks after accept; Result=0; Error=1.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// sign handled by magnitude conversion up front and correction at the end.
`timescale 1ns/1ps
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        aluop,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [4:0] OP_MUL  = 5'b10101;
  localparam logic [4:0] OP_MULH = 5'b10110;
  localparam logic [4:0] OP_MULU = 5'b10111;
  localparam logic [4:0] OP_DIV  = 5'b11010;
  localparam logic [4:0] OP_DIVU = 5'b11011;
  localparam logic [4:0] OP_REM  = 5'b11100;
  localparam logic [4:0] OP_REMU = 5'b11101;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [4:0]                op_r;
  logic signed [DATA_W-1:0]  a_r, b_r;
  logic [DATA_W-1:0]         hi, lo, dv;
  logic                      neg;

  logic                      is_mul, is_div, is_signed, supported, b_zero;
  logic [DATA_W:0]           mul_sum, shifted;
  logic                      q_bit;
  logic [DATA_W-1:0]         div_rem;
  logic [2*DATA_W-1:0]       prod_c;
  logic [DATA_W-1:0]         fix_res;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                            input logic en);
    return (en && x[DATA_W-1]) ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [DATA_W-1:0] sgn_fix(input logic [DATA_W-1:0] x,
                                                input logic n);
    return n ? (~x + DATA_W'(1)) : x;
  endfunction

  always_comb begin
    is_mul    = (op_r == OP_MUL) || (op_r == OP_MULH) || (op_r == OP_MULU);
    is_div    = (op_r == OP_DIV) || (op_r == OP_DIVU) ||
                (op_r == OP_REM) || (op_r == OP_REMU);
    is_signed = (op_r == OP_MUL) || (op_r == OP_MULH) ||
                (op_r == OP_DIV) || (op_r == OP_REM);
    supported = is_mul || is_div;
    b_zero    = (b_r == '0);

    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    shifted = {hi, lo[DATA_W-1]};
    q_bit   = (shifted >= {1'b0, dv});
    div_rem = q_bit ? DATA_W'(shifted - {1'b0, dv}) : shifted[DATA_W-1:0];

    prod_c = neg ? (~{hi, lo} + (2*DATA_W)'(1)) : {hi, lo};
    case (op_r)
      OP_MUL:          fix_res = prod_c[DATA_W-1:0];
      OP_MULH,
      OP_MULU:         fix_res = prod_c[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU: fix_res = sgn_fix(lo, neg);
      OP_REM, OP_REMU: fix_res = sgn_fix(hi, neg);
      default:         fix_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = supported ? CALC : FIX;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == PREP) || (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == PREP)      cnt <= '0;
      else if (state == CALC) cnt <= cnt + CNT_W'(1);
      if (state == FIX) begin
        result <= fix_res;
        error  <= !supported;
      end
    end
  end

  // Datapath: operands latch only on accept, so later input activity is ignored
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= aluop;
      end
      PREP: begin
        hi <= '0;
        if (is_div) begin
          lo  <= mag(a_r, is_signed);
          dv  <= mag(b_r, is_signed);
          // Divide by zero must return all-ones quotient, so never negate it
          if (op_r == OP_REM) neg <= a_r[DATA_W-1];
          else                neg <= is_signed && !b_zero && (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
        end else begin
          lo  <= mag(b_r, is_signed);
          dv  <= mag(a_r, is_signed);
          neg <= is_signed && (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
        end
      end
      CALC: begin
        if (is_div) begin
          hi <= div_rem;
          lo <= {lo[DATA_W-2:0], q_bit};
        end else begin
          hi <= mul_sum[DATA_W:1];
          lo <= {mul_sum[0], lo[DATA_W-1:1]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: results, latency, busy/done framing,
// ignored restarts and asynchronous reset abort.
`timescale 1ns/1ps
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  aluop;
  logic [31:0] a, b;
  logic        busy, done, error;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Assumes caller sits just after a rising edge; returns cycles from accept to done (0 = timeout)
  task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int lat);
    aluop = op; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone;
    logic [31:0] held;

    vecs.push_back('{"mul_10x5",     5'b10101, 32'd10,        32'd5,         32'd50,        1'b0, 34});
    vecs.push_back('{"div_m7_2",     5'b11010, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 34});
    vecs.push_back('{"rem_m7_2",     5'b11100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, 34});
    vecs.push_back('{"mulh_m1_m1",   5'b10110, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1'b0, 34});
    vecs.push_back('{"mulu_ff_ff",   5'b10111, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 34});
    vecs.push_back('{"divu_by0",     5'b11011, 32'd10,        32'd0,         32'hFFFFFFFF,  1'b0, 34});
    vecs.push_back('{"remu_by0",     5'b11101, 32'd10,        32'd0,         32'd10,        1'b0, 34});
    vecs.push_back('{"div_ovf",      5'b11010, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 34});
    vecs.push_back('{"rem_ovf",      5'b11100, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b0, 34});
    vecs.push_back('{"bad_op",       5'b00000, 32'd123,       32'd45,        32'h00000000,  1'b1, 2});
    vecs.push_back('{"mul_m3_7",     5'b10101, 32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  1'b0, 34});
    vecs.push_back('{"mulh_min_min", 5'b10110, 32'h80000000,  32'h80000000,  32'h40000000,  1'b0, 34});
    vecs.push_back('{"mulu_2p32",    5'b10111, 32'h80000000,  32'd2,         32'h00000001,  1'b0, 34});
    vecs.push_back('{"mulh_pos",     5'b10110, 32'h12345678,  32'h00000010,  32'h00000001,  1'b0, 34});
    vecs.push_back('{"divu_100_7",   5'b11011, 32'd100,       32'd7,         32'd14,        1'b0, 34});
    vecs.push_back('{"remu_100_7",   5'b11101, 32'd100,       32'd7,         32'd2,         1'b0, 34});
    vecs.push_back('{"div_7_m2",     5'b11010, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0, 34});
    vecs.push_back('{"rem_7_m2",     5'b11100, 32'd7,         32'hFFFFFFFE,  32'd1,         1'b0, 34});
    vecs.push_back('{"div_m5_by0",   5'b11010, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1'b0, 34});
    vecs.push_back('{"rem_m5_by0",   5'b11100, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b0, 34});

    reset = 1'b1; start = 1'b0; aluop = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, busy},  32'd0);
    chk("reset_done",   {31'd0, done},  32'd0);
    chk("reset_result", result,         32'd0);
    chk("reset_error",  {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      aluop = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({vecs[i].name, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = k;
          break;
        end
      end
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_result"}, result, vecs[i].res);
      chk({vecs[i].name, "_error"}, {31'd0, error}, {31'd0, vecs[i].err});
      chk({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk({vecs[i].name, "_result_hold"}, result, vecs[i].res);
      chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end

    // Restart attempt mid-operation and during the DONE cycle must both be ignored
    aluop = 5'b10101; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        aluop = 5'b11010; a = 32'd100; b = 32'd7; start = 1'b1;
      end else if (k == 11) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
        held = result;
        aluop = 5'b10101; a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("restart_done_count", ndone, 1);
    chk("restart_latency", lat, 34);
    chk("restart_result", held, 32'd12);
    chk("restart_idle_after", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of an operation
    aluop = 5'b10101; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_busy",   {31'd0, busy}, 32'd0);
    chk("async_reset_done",   {31'd0, done}, 32'd0);
    chk("async_reset_result", result,        32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_op(5'b10101, 32'd6, 32'd7, lat);
    chk("fresh_latency", lat, 34);
    chk("fresh_result", result, 32'd42);
    chk("fresh_error", {31'd0, error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
